// File: rtl/fsk_demod.sv
// rtl/fsk_demod.sv - 2-FSK demodulator: counts line transitions per bit window, assembles 16-bit frames
module fsk_demod #(
  parameter int SPB    = 64,
  parameter int THRESH = 20,
  parameter int LO_MAX = 12,
  parameter int HI_MIN = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fsk_in,
  input  logic        sync,
  output logic [15:0] data_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        bit_out,
  output logic        bit_valid
);

  localparam int CW = (SPB > 1) ? $clog2(SPB) : 1;
  localparam logic [CW-1:0] SAMP_LAST = CW'(SPB - 1);
  localparam logic [6:0] T_THRESH = 7'(THRESH);
  localparam logic [6:0] T_LO_MAX = 7'(LO_MAX);
  localparam logic [6:0] T_HI_MIN = 7'(HI_MIN);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic          fsk_m, fsk_s, fsk_p;
  logic          trans;
  logic [CW-1:0] samp_cnt;
  logic [6:0]    trans_cnt;
  logic [6:0]    t;
  logic [3:0]    bit_idx;
  logic [15:0]   shreg;
  logic          err_acc;
  logic          decide, bit_dec, ambig;

  assign trans   = fsk_s ^ fsk_p;
  // The decision must include the transition seen on the window's last cycle.
  assign t       = trans_cnt + {6'd0, trans};
  assign bit_dec = (t >= T_THRESH);
  assign ambig   = (t > T_LO_MAX) && (t < T_HI_MIN);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    decide     = 1'b0;
    if (sync) begin
      state_next = RUN;
    end else if (state == RUN) begin
      decide = (samp_cnt == SAMP_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsk_m       <= 1'b0;
      fsk_s       <= 1'b0;
      fsk_p       <= 1'b0;
      samp_cnt    <= '0;
      trans_cnt   <= 7'd0;
      bit_idx     <= 4'd0;
      shreg       <= 16'h0000;
      err_acc     <= 1'b0;
      data_out    <= 16'h0000;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
    end else begin
      fsk_m       <= fsk_in;
      fsk_s       <= fsk_m;
      fsk_p       <= fsk_s;
      bit_valid   <= 1'b0;
      frame_valid <= 1'b0;
      // sync wins over a coincident decision: the partial frame is dropped.
      if (sync) begin
        samp_cnt  <= '0;
        trans_cnt <= 7'd0;
        bit_idx   <= 4'd15;
        shreg     <= 16'h0000;
        err_acc   <= 1'b0;
      end else if (state == RUN) begin
        if (decide) begin
          samp_cnt  <= '0;
          trans_cnt <= 7'd0;
          bit_out   <= bit_dec;
          bit_valid <= 1'b1;
          if (bit_idx == 4'd0) begin
            data_out    <= {shreg[14:0], bit_dec};
            frame_err   <= err_acc | ambig;
            frame_valid <= 1'b1;
            bit_idx     <= 4'd15;
            shreg       <= 16'h0000;
            err_acc     <= 1'b0;
          end else begin
            bit_idx <= bit_idx - 4'd1;
            shreg   <= {shreg[14:0], bit_dec};
            err_acc <= err_acc | ambig;
          end
        end else begin
          samp_cnt  <= samp_cnt + CW'(1);
          trans_cnt <= t;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsk_demod.sv
// tb/tb_fsk_demod.sv - self-checking bench for fsk_demod: directed frame tables plus randomized windows vs a counting model
module tb_fsk_demod;
  localparam int SPB = 64, THRESH = 20, LO_MAX = 12, HI_MIN = 24;

  logic clk = 1'b0, rst = 1'b0, fsk_in = 1'b0, sync = 1'b0;
  logic [15:0] data_out;
  logic frame_valid, frame_err, bit_out, bit_valid;

  fsk_demod #(.SPB(SPB), .THRESH(THRESH), .LO_MAX(LO_MAX), .HI_MIN(HI_MIN)) dut (
    .clk(clk), .rst(rst), .fsk_in(fsk_in), .sync(sync),
    .data_out(data_out), .frame_valid(frame_valid), .frame_err(frame_err),
    .bit_out(bit_out), .bit_valid(bit_valid)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit stim[$];
  int sync_q[$], rst_q[$];
  bit lvl = 1'b0;
  bit got_bits[$], exp_bits[$];
  logic [16:0] got_fr[$], exp_fr[$];
  int got_fst[$], got_sst[$];
  int cyc = 0;
  bit mon_en = 1'b0, rst_d = 1'b0;
  int halves[7] = '{2, 3, 4, 5, 6, 8, 16};

  typedef struct { logic [15:0] frame; int force_k; logic [15:0] exp_data; logic exp_err; } vec_t;
  typedef struct { int t[16]; logic [15:0] exp_data; logic exp_err; } tvec_t;
  vec_t  vecs[5];
  tvec_t tvecs[2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_d) check("rst_outputs_zero", {12'd0, data_out, frame_valid, frame_err, bit_out, bit_valid}, 32'd0);
      if (bit_valid) got_bits.push_back(bit_out);
      if (frame_valid) begin
        check("frame_valid_with_bit_valid", {31'd0, bit_valid}, 32'd1);
        got_fr.push_back({data_out, frame_err});
        got_fst.push_back(cyc);
      end
      // first RUN cycle follows the cycle in which sync is seen
      if (sync) got_sst.push_back(cyc + 1);
      rst_d = !rst;
    end
  end

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[k]) if (q[k] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [16:0] fr_at(input int i);
    return (i < got_fr.size()) ? got_fr[i] : 17'hx;
  endfunction

  task automatic new_scn();
    stim.delete(); sync_q.delete(); rst_q.delete();
  endtask

  task automatic add_idle(input int n);
    for (int p = 0; p < n; p++) stim.push_back(lvl);
  endtask

  // continuous-phase tone: level flips every `half` samples
  task automatic add_tog(input int half, input int n);
    for (int p = 0; p < n; p++) begin
      if (p % half == 0) lvl = !lvl;
      stim.push_back(lvl);
    end
  endtask

  task automatic add_cnt(input int n);
    for (int p = 0; p < SPB; p++) begin
      if (p < n) lvl = !lvl;
      stim.push_back(lvl);
    end
  endtask

  task automatic add_frame(input logic [15:0] f, input int force_k);
    for (int k = 0; k < 16; k++) begin
      if (k == force_k) add_tog(4, SPB);
      else add_tog(f[15-k] ? 2 : 8, SPB);
    end
  endtask

  task automatic mark_sync();
    sync_q.push_back(stim.size() + 1);
  endtask

  task automatic rand_win();
    if ($urandom_range(1, 0) == 1) add_cnt($urandom_range(64, 0));
    else add_tog(halves[$urandom_range(6, 0)], SPB);
  endtask

  // Expected bits/frames: every window after a sync is decided unless the next sync or reset lands first.
  task automatic model();
    int len;
    len = stim.size();
    exp_bits.delete(); exp_fr.delete();
    foreach (sync_q[a]) begin
      int q, kill, s, cnt, t;
      logic [15:0] sh;
      bit acc, b;
      q = sync_q[a]; kill = len; s = q - 1; cnt = 0; sh = 16'h0; acc = 1'b0;
      foreach (sync_q[c]) if (sync_q[c] > q && sync_q[c] < kill) kill = sync_q[c];
      foreach (rst_q[c])  if (rst_q[c] > q && rst_q[c] < kill) kill = rst_q[c];
      for (int k = 0; s + SPB * k + SPB - 1 + 2 < kill; k++) begin
        t = 0;
        for (int j = s + SPB * k; j < s + SPB * (k + 1); j++) if (stim[j] != stim[j-1]) t++;
        b = (t >= THRESH);
        exp_bits.push_back(b);
        sh = {sh[14:0], b};
        acc |= (t > LO_MAX && t < HI_MIN);
        cnt++;
        if (cnt == 16) begin
          exp_fr.push_back({sh, acc});
          cnt = 0; acc = 1'b0;
        end
      end
    end
  endtask

  task automatic play(input string tag);
    got_bits.delete(); got_fr.delete(); got_fst.delete(); got_sst.delete();
    mon_en = 1'b1;
    for (int i = 0; i <= stim.size(); i++) begin
      @(posedge clk); #1;
      fsk_in = (i < stim.size()) ? stim[i] : lvl;
      sync   = in_q(sync_q, i);
      rst    = !(in_q(rst_q, i) || i == stim.size());
    end
    @(posedge clk); #1;
    rst = 1'b1; sync = 1'b0;
    @(posedge clk);
    mon_en = 1'b0;
    model();
    check($sformatf("%s_nbits", tag), got_bits.size(), exp_bits.size());
    for (int i = 0; i < exp_bits.size(); i++)
      check($sformatf("%s_bit%0d", tag, i), (i < got_bits.size()) ? {31'd0, got_bits[i]} : 32'hx, {31'd0, exp_bits[i]});
    check($sformatf("%s_nframes", tag), got_fr.size(), exp_fr.size());
    for (int i = 0; i < exp_fr.size(); i++)
      check($sformatf("%s_frame%0d", tag, i), fr_at(i), exp_fr[i]);
  endtask

  task automatic check_const_frame(input string tag, input logic [15:0] d, input logic e);
    check({tag, "_count"}, got_fr.size(), 1);
    check({tag, "_data_err"}, fr_at(0), {d, e});
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_seq%0d", tag, k), (k < got_bits.size()) ? {31'd0, got_bits[k]} : 32'hx, {31'd0, d[15-k]});
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, -1, 16'hA5C3, 1'b0};
    vecs[1] = '{16'h8001,  0, 16'h0001, 1'b1};
    vecs[2] = '{16'h1234, -1, 16'h1234, 1'b0};
    vecs[3] = '{16'h8001,  7, 16'h8001, 1'b1};
    vecs[4] = '{16'h0F0F, -1, 16'h0F0F, 1'b0};
    tvecs[0] = '{'{19, 20, 12, 13, 23, 24, 0, 64, 20, 19, 32, 8, 16, 11, 25, 21}, 16'h4DA3, 1'b1};
    tvecs[1] = '{'{12, 24, 12, 24, 12, 24, 12, 24, 12, 24, 12, 24, 12, 24, 12, 24}, 16'h5555, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", {16'd0, data_out}, 32'd0);
    check("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_bit_out", {31'd0, bit_out}, 32'd0);
    check("reset_bit_valid", {31'd0, bit_valid}, 32'd0);
    rst = 1'b1;

    // activity without sync must stay silent
    new_scn();
    for (int i = 0; i < 200; i++) stim.push_back(1'($urandom_range(1, 0)));
    lvl = stim[stim.size()-1];
    play("idle_no_sync");
    check("idle_no_bits", got_bits.size(), 0);

    foreach (vecs[v]) begin
      new_scn(); add_idle(5); mark_sync();
      add_frame(vecs[v].frame, vecs[v].force_k); add_idle(4);
      play($sformatf("vec%0d", v));
      check_const_frame($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_err);
    end

    foreach (tvecs[v]) begin
      new_scn(); add_idle(5); mark_sync();
      for (int k = 0; k < 16; k++) add_cnt(tvecs[v].t[k]);
      add_idle(4);
      play($sformatf("tvec%0d", v));
      check_const_frame($sformatf("tvec%0d", v), tvecs[v].exp_data, tvecs[v].exp_err);
    end

    // back-to-back frames from a single sync
    new_scn(); add_idle(5); mark_sync();
    add_frame(16'hFFFF, -1); add_frame(16'h0000, -1); add_idle(4);
    play("b2b");
    check("b2b_count", got_fr.size(), 2);
    check("b2b_first", fr_at(0), {16'hFFFF, 1'b0});
    check("b2b_second", fr_at(1), {16'h0000, 1'b0});
    check("b2b_spacing", (got_fst.size() > 1) ? got_fst[1] - got_fst[0] : -1, 16 * SPB);

    // resync mid-window at bit index 7
    new_scn(); add_idle(5); mark_sync();
    for (int k = 0; k < 8; k++) add_tog(vecs[0].frame[15-k] ? 2 : 8, SPB);
    add_tog(2, 29); mark_sync();
    add_frame(16'h3C5A, -1); add_idle(4);
    play("resync");
    check("resync_count", got_fr.size(), 1);
    check("resync_frame", fr_at(0), {16'h3C5A, 1'b0});
    check("resync_latency", (got_fst.size() > 0 && got_sst.size() > 1) ? got_fst[0] - got_sst[1] : -1, 16 * SPB);

    // sync on the decision cycle of window 4: that bit is suppressed
    new_scn(); add_idle(5); mark_sync();
    for (int k = 0; k < 5; k++) add_tog(vecs[0].frame[15-k] ? 2 : 8, SPB);
    sync_q.push_back(stim.size() + 1);
    add_frame(16'h0F0F, -1); add_idle(4);
    play("sync_on_decide");
    check("sync_on_decide_nbits", got_bits.size(), 4 + 16);
    check("sync_on_decide_frame", fr_at(0), {16'h0F0F, 1'b0});
    check("sync_on_decide_latency", (got_fst.size() > 0 && got_sst.size() > 1) ? got_fst[0] - got_sst[1] : -1, 16 * SPB);

    // one-cycle reset at bit index 4, idle, then a fresh sync
    new_scn(); add_idle(5); mark_sync();
    for (int k = 0; k < 11; k++) add_tog(vecs[0].frame[15-k] ? 2 : 8, SPB);
    add_tog(2, 20);
    rst_q.push_back(stim.size());
    add_tog(2, 40);
    mark_sync();
    add_frame(16'h1234, -1); add_idle(4);
    play("mid_reset");
    check("mid_reset_nbits", got_bits.size(), 11 + 16);
    check("mid_reset_count", got_fr.size(), 1);
    check("mid_reset_frame", fr_at(0), {16'h1234, 1'b0});

    for (int r = 0; r < 6; r++) begin
      int nw1, nw2, part;
      nw1 = $urandom_range(20, 1); part = $urandom_range(63, 0); nw2 = $urandom_range(32, 16);
      new_scn(); add_idle(5); mark_sync();
      for (int k = 0; k < nw1; k++) rand_win();
      add_tog(2, part);
      mark_sync();
      for (int k = 0; k < nw2; k++) rand_win();
      add_idle(4);
      play($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fsk_demod.md
FSK_DEMOD -- requirements
Module: fsk_demod

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- SPB, 64, sampling-clock cycles per bit window (16 transmitter clocks at 4x oversampling).
- THRESH, 20, minimum transition count for a bit to be decided as 1.
- LO_MAX, 12, highest transition count that is a clean 0.
- HI_MIN, 24, lowest transition count that is a clean 1.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, sampling clock at 4x the modulator clock.
- rst, input, 1, reset: synchronous, active-low; clock clk.
- fsk_in, input, 1, 2-FSK line signal (fast tone = 1, slow tone = 0), asynchronous to clk.
- sync, input, 1, one-cycle pulse marking the start of a frame's MSB window.
- data_out, output, 16, last complete demodulated frame, MSB first on the line.
- frame_valid, output, 1, one-cycle pulse when data_out updates.
- frame_err, output, 1, set with frame_valid if any bit in that frame was ambiguous.
- bit_out, output, 1, most recent decided bit.
- bit_valid, output, 1, one-cycle pulse when bit_out updates.

Function
REQ-003 fsk_in SHALL pass through a 2-flop synchronizer; the second stage output is fsk_s. Transition detect SHALL be fsk_s != fsk_p, where fsk_p is fsk_s delayed one cycle.
REQ-004 The FSM SHALL have two states:
- IDLE: counters held at 0, no outputs pulse.
- RUN: demodulating.
REQ-005 sync=1 in IDLE or RUN SHALL enter RUN next cycle with samp_cnt=0, trans_cnt=0, bit_idx=15, and shift register and frame error accumulator cleared. A partial frame SHALL be discarded without frame_valid.
REQ-006 In RUN, each cycle:
- samp_cnt SHALL increment by 1, wrapping from SPB-1 to 0.
- trans_cnt (7 bits) SHALL add 1 per detected transition.
REQ-007 On the cycle samp_cnt==SPB-1, the bit decision SHALL use t = trans_cnt plus that cycle's transition. The bit is 1 if t>=THRESH, else 0.
REQ-008 At a decision:
- bit_out SHALL take the decided bit and bit_valid SHALL pulse on the next cycle.
- The bit SHALL shift into the shift register LSB.
- trans_cnt SHALL clear to 0.
REQ-009 A bit SHALL be ambiguous when LO_MAX < t < HI_MIN. An ambiguous bit SHALL set the frame error accumulator; the bit is still decided per REQ-007.
REQ-010 At the decision with bit_idx==0:
- data_out SHALL load the 16-bit frame, which includes the current bit.
- frame_err SHALL load the accumulator, including the current bit.
- frame_valid SHALL pulse, coincident with that bit_valid.
- bit_idx SHALL wrap to 15, and the accumulator and shift register SHALL clear.
- Otherwise, bit_idx SHALL decrement.
REQ-011 After a frame completes, demodulation SHALL continue back-to-back without a new sync, matching the continuous modulator.
REQ-012 sync on the same cycle as a decision SHALL take priority: no bit_valid or frame_valid, and a restart per REQ-005.
REQ-013 Latency: the bit line boundary to bit_valid SHALL be SPB+3 cycles (2 synchronizer + 1 register).
REQ-014 data_out, frame_err, and bit_out SHALL hold their values between updates.

Reset
REQ-015 With rst=0 at a clk edge:
- FSM goes to IDLE.
- data_out=16'h0000; frame_valid, frame_err, bit_out, and bit_valid = 0.
- All counters, the synchronizer, and the shift register = 0.
REQ-016 Reset mid-frame SHALL abort the frame with no frame_valid. After reset, the block SHALL stay in IDLE until sync.

Verification
REQ-017 Frame 16'hA5C3 from a 4x-oversampled modulator model, sync aligned to the MSB window -> after 16*64 cycles, frame_valid=1, data_out=16'hA5C3, frame_err=0; 16 bit_valid pulses with sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
REQ-018 Continuous frames 16'hFFFF then 16'h0000, single sync -> two frame_valid pulses exactly 1024 cycles apart, data_out 16'hFFFF then 16'h0000, and t=32 / t=8 per bit respectively.
REQ-019 One bit window of frame 16'h8001 forced to exactly 16 transitions -> that bit decided 0 (16<20), frame_err=1 on frame_valid; the next clean frame gives frame_err=0.
REQ-020 sync reasserted at bit index 7 -> no frame_valid for the partial frame; the next frame_valid arrives 1024 cycles after the second sync.
REQ-021 rst=0 for 1 cycle at bit index 4 -> all outputs 0 next cycle, no frame_valid until sync; after sync, 16'h1234 decoded correctly.
REQ-022 sync coincident with samp_cnt==63 -> no bit_valid that cycle, and samp_cnt=0, bit_idx=15 next cycle.
